// File: rtl/regression_sequencer.sv
// Top-level phase sequencer for the linear-regression engine: accumulation pass,
// coefficient handshake, then error pass over the sample memory.
module regression_sequencer #(
  parameter int N_SAMPLES = 150,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              coeff_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              acc_clr,
  output logic              acc_ld,
  output logic              coeff_start,
  output logic              err_ld,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    LOAD,
    LOAD_DRAIN,
    C_START,
    C_BUSY,
    C_WAIT,
    ERR,
    ERR_DRAIN,
    FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rd_q, rd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start) state_d = CLR;
      CLR: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD, ERR: begin
        // Explicit return to 0 keeps N_SAMPLES = 2^ADDR_W from relying on wrap.
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = (state_q == LOAD) ? LOAD_DRAIN : ERR_DRAIN;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      LOAD_DRAIN: state_d = C_START;
      C_START:    state_d = C_BUSY;
      C_BUSY:     if (!coeff_done) state_d = C_WAIT;
      C_WAIT:     if (coeff_done) state_d = ERR;
      ERR_DRAIN:  state_d = FIN;
      FIN:        state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Read data lands one cycle after the strobe, so loads are qualified by rd_q.
  assign rd_d        = mem_rd;
  assign mem_rd      = (state_q == LOAD) || (state_q == ERR);
  assign mem_addr    = cnt_q;
  assign acc_clr     = (state_q == CLR);
  assign acc_ld      = rd_q && ((state_q == LOAD) || (state_q == LOAD_DRAIN));
  assign err_ld      = rd_q && ((state_q == ERR) || (state_q == ERR_DRAIN));
  assign coeff_start = (state_q == C_START);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);

endmodule

// File: tb/tb_regression_sequencer.sv
// Randomized bench for regression_sequencer: two instances (N=4/ADDR_W=8 and
// N=8/ADDR_W=3) checked cycle by cycle against a timeline model of a run.
module tb_regression_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_r [2];
  logic cd_r    [2];
  logic [7:0] obs_addr [2];
  logic [6:0] obs_bits [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] a4_addr;
  logic [2:0] a8_addr;
  logic a4_rd, a4_clr, a4_acc, a4_cs, a4_err, a4_busy, a4_done;
  logic a8_rd, a8_clr, a8_acc, a8_cs, a8_err, a8_busy, a8_done;

  regression_sequencer #(.N_SAMPLES(4), .ADDR_W(8)) u4 (
    .clk(clk), .rst(rst), .start(start_r[0]), .coeff_done(cd_r[0]),
    .mem_addr(a4_addr), .mem_rd(a4_rd), .acc_clr(a4_clr), .acc_ld(a4_acc),
    .coeff_start(a4_cs), .err_ld(a4_err), .busy(a4_busy), .done(a4_done)
  );

  regression_sequencer #(.N_SAMPLES(8), .ADDR_W(3)) u8 (
    .clk(clk), .rst(rst), .start(start_r[1]), .coeff_done(cd_r[1]),
    .mem_addr(a8_addr), .mem_rd(a8_rd), .acc_clr(a8_clr), .acc_ld(a8_acc),
    .coeff_start(a8_cs), .err_ld(a8_err), .busy(a8_busy), .done(a8_done)
  );

  // Bundle order: {mem_rd, acc_clr, acc_ld, coeff_start, err_ld, busy, done}
  assign obs_addr[0] = a4_addr;
  assign obs_addr[1] = {5'b0, a8_addr};
  assign obs_bits[0] = {a4_rd, a4_clr, a4_acc, a4_cs, a4_err, a4_busy, a4_done};
  assign obs_bits[1] = {a8_rd, a8_clr, a8_acc, a8_cs, a8_err, a8_busy, a8_done};

  // Coefficient controller model: idle-high, drops a cycles after coeff_start
  // (coeff_start occupies cycle n+3) and stays low for b cycles.
  function automatic logic cd_val(input int k, input int n, input int a, input int b);
    return !((k >= n + 3 + a) && (k < n + 3 + a + b));
  endfunction

  // One complete run; cycle k is the clock period that ends at edge k, and
  // the start request is sampled at edge 0.
  task automatic run(input int idx, input int n, input int a, input int b, input bit hold);
    int t1, t2, f, last_k;
    logic [6:0] ev;
    logic [7:0] ea;
    bit ld_pass, er_pass;
    t1 = n + 4;
    while (cd_val(t1, n, a, b) && t1 < 500) t1++;
    t2 = t1 + 1;
    while (!cd_val(t2, n, a, b) && t2 < 500) t2++;
    f = t2 + n + 2;
    last_k = hold ? f : f + 1;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      if (k == 0)      start_r[idx] = 1'b1;
      else if (k > f)  start_r[idx] = 1'b0;
      else if (hold)   start_r[idx] = 1'b1;
      else             start_r[idx] = 1'($urandom_range(0, 1));
      cd_r[idx] = cd_val(k, n, a, b);
      ld_pass = (k >= 2) && (k <= n + 1);
      er_pass = (k >= t2 + 1) && (k <= t2 + n);
      ea = ld_pass ? 8'(k - 2) : er_pass ? 8'(k - t2 - 1) : 8'd0;
      ev = {ld_pass || er_pass,
            k == 1,
            (k >= 3) && (k <= n + 2),
            k == n + 3,
            (k >= t2 + 2) && (k <= t2 + n + 1),
            (k >= 1) && (k <= f),
            k == f};
      checks++;
      if (obs_addr[idx] !== ea) begin
        failures++;
        $display("FAIL addr u%0d cyc%0d got %0d want %0d", idx, k, obs_addr[idx], ea);
      end
      checks++;
      if (obs_bits[idx] !== ev) begin
        failures++;
        $display("FAIL ctl u%0d cyc%0d got %b want %b (rd,clr,acc,cs,err,busy,done)",
                 idx, k, obs_bits[idx], ev);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_bits[i] !== 7'd0 || obs_addr[i] !== 8'd0) begin
        failures++;
        $display("FAIL reset u%0d got %b/%0d want 0/0", i, obs_bits[i], obs_addr[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run(0, 4, 1, 5, 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      run(r % 2, (r % 2) ? 8 : 4, int'($urandom_range(1, 5)), int'($urandom_range(1, 6)), 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 3; r++) run(0, 4, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), 1'b1);
    run(0, 4, 2, 2, 1'b0);
  endtask

  task automatic test_hang;
    run(0, 4, 12, 3, 1'b0);
  endtask

  task automatic test_full_range;
    run(1, 8, 1, 1, 1'b0);
    run(1, 8, 3, 4, 1'b0);
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      start_r[0] = (k == 0);
      cd_r[0] = 1'b1;
    end
    checks++;
    if (obs_addr[0] !== 8'd2 || a4_rd !== 1'b1) begin
      failures++;
      $display("FAIL midload u0 got addr %0d rd %b want 2 1", obs_addr[0], a4_rd);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs_bits[0] !== 7'd0 || obs_addr[0] !== 8'd0) begin
      failures++;
      $display("FAIL async_reset u0 got %b/%0d want 0/0", obs_bits[0], obs_addr[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    run(0, 4, 2, 3, 1'b0);
  endtask

  initial begin
    start_r[0] = 1'b0; start_r[1] = 1'b0;
    cd_r[0] = 1'b1;    cd_r[1] = 1'b1;
    test_reset;
    test_basic;
    test_random;
    test_back_to_back;
    test_hang;
    test_full_range;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
